// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: on an int_req edge drains the pipeline, pushes {flags, PC hi, PC lo} through the execute push path, then loads PC with INT_VECTOR
module interrupt_sequencer #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic [31:0] ex_pc_plus_one,
  input  logic [2:0]  flag_register,
  output logic        stall_fetch,
  output logic        flush_decode,
  output logic        inject_push,
  output logic [15:0] inject_data,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        int_ack,
  output logic        busy
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH_FLAGS, PUSH_PC_HI, PUSH_PC_LO, JUMP} state_t;
  state_t        state_q, state_d;
  logic          prev_req_q, prev_req_d;
  logic          pending_q, pending_d;
  logic [31:0]   resume_pc_q, resume_pc_d;
  logic [2:0]    saved_flags_q, saved_flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          int_edge, accept, push_state;
  assign int_edge   = int_req & ~prev_req_q;
  assign accept     = (state_q == IDLE) & (int_edge | pending_q) & ~branch_taken & ~mem_busy;
  assign push_state = state_q inside {PUSH_FLAGS, PUSH_PC_HI, PUSH_PC_LO};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prev_req_q    <= 1'b0;
      pending_q     <= 1'b0;
      resume_pc_q   <= '0;
      saved_flags_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      prev_req_q    <= prev_req_d;
      pending_q     <= pending_d;
      resume_pc_q   <= resume_pc_d;
      saved_flags_q <= saved_flags_d;
      cnt_q         <= cnt_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    prev_req_d    = int_req;
    pending_d     = (pending_q | int_edge) & ~accept;
    resume_pc_d   = accept ? ex_pc_plus_one : resume_pc_q;
    saved_flags_d = saved_flags_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d       = PUSH_FLAGS;
          saved_flags_d = flag_register;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PUSH_FLAGS: state_d = mem_busy ? PUSH_FLAGS : PUSH_PC_HI;
      PUSH_PC_HI: state_d = mem_busy ? PUSH_PC_HI : PUSH_PC_LO;
      PUSH_PC_LO: state_d = mem_busy ? PUSH_PC_LO : JUMP;
      JUMP:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    busy          = state_q != IDLE;
    stall_fetch   = busy & (state_q != JUMP);
    flush_decode  = busy;
    inject_push   = push_state & ~mem_busy;
    inject_data   = !inject_push ? 16'h0 :
                    state_q == PUSH_FLAGS ? {13'b0, saved_flags_q} :
                    state_q == PUSH_PC_HI ? resume_pc_q[31:16] : resume_pc_q[15:0];
    pc_load       = state_q == JUMP;
    pc_load_value = pc_load ? INT_VECTOR : 32'h0;
    int_ack       = pc_load;
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: scoreboard bench comparing interrupt_sequencer against a per-service timeline model under directed and random stimulus
module tb_interrupt_sequencer;
  localparam int          D   = 2;
  localparam logic [31:0] VEC = 32'h0000_8040;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        int_req = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic [31:0] ex_pc_plus_one = '0;
  logic [2:0]  flag_register = '0;
  logic        stall_fetch, flush_decode, inject_push, pc_load, int_ack, busy;
  logic [15:0] inject_data;
  logic [31:0] pc_load_value;
  int          checks = 0, errors = 0;
  bit          rand_data = 1'b1;
  logic [5:0]  ctl_q[$];
  logic [15:0] push_q[$];
  logic [31:0] ack_q[$];
  interrupt_sequencer #(.DRAIN_CYCLES(D), .INT_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .ex_pc_plus_one(ex_pc_plus_one), .flag_register(flag_register),
    .stall_fetch(stall_fetch), .flush_decode(flush_decode), .inject_push(inject_push),
    .inject_data(inject_data), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .int_ack(int_ack), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  // Reference: age counts cycles since acceptance, done counts completed pushes.
  int          age = -1, done = 0;
  logic        m_prev = 1'b0, m_pend = 1'b0;
  logic [31:0] m_pc = '0;
  logic [2:0]  m_flags = '0;
  always @(negedge clk) begin
    logic s, f, p, l, a, b, edge_seen, acc;
    logic [15:0] w;
    {s, f, p, l, a, b} = '0;
    acc = 1'b0;
    if (reset) begin
      age = -1; done = 0; m_prev = 1'b0; m_pend = 1'b0;
    end else begin
      edge_seen = int_req && !m_prev;
      if (age < 0) begin
        acc = (edge_seen || m_pend) && !branch_taken && !mem_busy;
        if (acc) m_pc = ex_pc_plus_one;
      end else begin
        {s, f, b} = 3'b111;
        if (age < D) begin
          if (age == D - 1) m_flags = flag_register;
          age++;
        end else if (done < 3) begin
          w = done == 0 ? {13'b0, m_flags} : done == 1 ? m_pc[31:16] : m_pc[15:0];
          if (!mem_busy) begin
            p = 1'b1;
            push_q.push_back(w);
            done++;
          end
        end else begin
          s = 1'b0; l = 1'b1; a = 1'b1;
          ack_q.push_back(VEC);
          age = -1; done = 0;
        end
      end
      if (acc) age = 0;
      m_pend = (m_pend || edge_seen) && !acc;
      m_prev = int_req;
    end
    ctl_q.push_back({s, f, p, l, a, b});
  end
  always @(negedge clk) begin
    #1;
    chk("ctl_pending", ctl_q.size() > 0, 1);
    if (ctl_q.size() > 0)
      chk("ctl_bits", {stall_fetch, flush_decode, inject_push, pc_load, int_ack, busy}, ctl_q.pop_front());
    if (inject_push) begin
      chk("push_pending", push_q.size() > 0, 1);
      if (push_q.size() > 0) chk("push_data", inject_data, push_q.pop_front());
    end else chk("push_data_idle", inject_data, 0);
    if (int_ack) begin
      chk("ack_pending", ack_q.size() > 0, 1);
      if (ack_q.size() > 0) chk("pc_load_value", pc_load_value, ack_q.pop_front());
    end else chk("pc_value_idle", pc_load_value, 0);
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_data) begin
      flag_register  = 3'($urandom);
      ex_pc_plus_one = $urandom;
    end
  endtask
  task automatic idle(input int n);
    int_req = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
    repeat (n) step();
  endtask
  task automatic run_seq(input logic [31:0] rq, input logic [31:0] bz, input logic [31:0] bt,
                         input int n, output int acks, output int first);
    acks = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      int_req = rq[k]; mem_busy = bz[k]; branch_taken = bt[k];
      @(negedge clk);
      #2;
      if (int_ack) begin
        acks++;
        if (first < 0) first = k;
      end
      step();
    end
    int_req = 1'b0; mem_busy = 1'b0; branch_taken = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int acks, first;
    step();
    step();
    chk("reset_outputs", {stall_fetch, flush_decode, inject_push, pc_load, int_ack, busy, inject_data, pc_load_value}, 0);
    step();
    reset = 1'b0;
    idle(4);
    rand_data = 1'b0;
    flag_register = 3'b101;
    ex_pc_plus_one = 32'h0001_2345;
    run_seq(32'h1, 32'h0, 32'h0, 12, acks, first);
    chk("basic_ack_cycle", first, D + 4);
    chk("basic_acks", acks, 1);
    rand_data = 1'b1;
    idle(4);
    run_seq(32'h1, 32'h0, 32'h7, 16, acks, first);
    chk("branch_ack_cycle", first, D + 7);
    idle(4);
    run_seq(32'h1, 32'h3 << (D + 2), 32'h0, 16, acks, first);
    chk("busy_ack_cycle", first, D + 6);
    chk("busy_acks", acks, 1);
    idle(4);
    run_seq(32'h2B, 32'h0, 32'h0, 20, acks, first);
    chk("queued_acks", acks, 2);
    chk("queued_first_ack", first, D + 4);
    idle(4);
    run_seq(32'hF_FFFF, 32'h0, 32'h0, 26, acks, first);
    chk("level_hold_acks", acks, 1);
    idle(4);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    repeat (3) step();
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("reset_mid_outputs", {stall_fetch, flush_decode, inject_push, pc_load, int_ack, busy, inject_data, pc_load_value}, 0);
    step();
    step();
    reset = 1'b0;
    run_seq(32'h0, 32'h0, 32'h0, 12, acks, first);
    chk("no_service_after_reset", acks, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) int_req = ~int_req;
      branch_taken = $urandom_range(4) == 0;
      mem_busy     = $urandom_range(3) == 0;
      reset        = $urandom_range(499) == 0;
      step();
    end
    reset = 1'b0;
    idle(20);
    chk("push_q_drained", push_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
